// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_pkg
// Brief   : FSM states, interrupt source codes and control-code bit indices
//           shared by the interrupt controller files.
// Revision: 1.0 - initial release
// ============================================================================
package int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_SERVICE = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_SOFT = 2'd3
    } src_t;

    localparam int c_CODE_W       = 12;
    localparam int c_BIT_A_EN     = 0;
    localparam int c_BIT_B_EN     = 1;
    localparam int c_BIT_PRIO     = 2;
    localparam int c_BIT_SET_INFO = 3;
    localparam int c_BIT_ADDR_LO  = 4;
    localparam int c_BIT_ADDR_HI  = 5;
    localparam int c_BIT_SOFT     = 6;
    localparam int c_BIT_NUM_LO   = 7;
    localparam int c_BIT_NUM_HI   = 11;

    localparam logic [1:0] c_ADDR_SET_A   = 2'd1;
    localparam logic [1:0] c_ADDR_SET_B   = 2'd2;
    localparam logic [1:0] c_ADDR_DEFAULT = 2'd3;

    // Soft vector table entries are two words apart; wraps modulo 2^16.
    function automatic logic [15:0] soft_vector(input logic [15:0] base,
                                                input logic [4:0]  num);
        return base + {10'd0, num, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : int_controller_if
// Brief   : Decoder/PC-facing signal bundle of the interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
interface int_controller_if;
    import int_pkg::*;

    logic [c_CODE_W-1:0] i_ct_control_code;
    logic [15:0]         i_data_bus;
    logic                i_inta;
    logic                i_intb;
    logic                i_iret;
    logic                o_interrupt;
    logic                o_restore;
    logic                o_pc_load;
    logic [15:0]         o_vector;
    logic                o_inta_ack;
    logic                o_intb_ack;
    logic                o_int_active;
    logic [1:0]          o_int_source;
    logic [7:0]          o_drop_cnt;

    modport master (
        output i_ct_control_code, i_data_bus, i_inta, i_intb, i_iret,
        input  o_interrupt, o_restore, o_pc_load, o_vector, o_inta_ack,
               o_intb_ack, o_int_active, o_int_source, o_drop_cnt
    );

    modport slave (
        input  i_ct_control_code, i_data_bus, i_inta, i_intb, i_iret,
        output o_interrupt, o_restore, o_pc_load, o_vector, o_inta_ack,
               o_intb_ack, o_int_active, o_int_source, o_drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/int_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : int_edge_sync
// Brief   : SYNC_STAGES flop synchronizer with a one-cycle rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module int_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// Module  : int_controller
// Brief   : Arbitrates lines A/B and soft interrupts, sequences decoder
//           save/restore and PC vector load. Option: INT_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module int_controller
    import int_pkg::*;
#(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [15:0] INTA_DEFAULT  = 16'h0010,
    parameter logic [15:0] INTB_DEFAULT  = 16'h0020,
    parameter logic [15:0] SOFT_VEC_BASE = 16'h0040
) (
    input  logic             clk,
    input  logic             n_rst,
    int_controller_if.slave  bus
);

    state_t        r_state, w_state_nxt;
    src_t          r_src, w_src_nxt, w_sel;
    logic          r_en_a, r_en_b, r_prio;
    logic [15:0]   r_vec_a, r_vec_b;
    logic          r_pend_a, r_pend_b, r_softreq;
    logic [4:0]    r_soft_num;
    logic          w_rise_a, w_rise_b, w_ack_a, w_ack_b, w_soft_accept;
    logic          w_elig_a, w_elig_b;
    logic [1:0]    w_addr_op;
    logic [15:0]   w_vector;
    logic [c_CODE_W-1:0] w_code;

    int_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .n_rst(n_rst), .i_async(bus.i_inta), .o_rise(w_rise_a)
    );
    int_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .n_rst(n_rst), .i_async(bus.i_intb), .o_rise(w_rise_b)
    );

    assign w_code        = bus.i_ct_control_code;
    assign w_addr_op     = w_code[c_BIT_ADDR_HI:c_BIT_ADDR_LO];
    assign w_ack_a       = (r_state == ST_VECTOR) && (r_src == SRC_A);
    assign w_ack_b       = (r_state == ST_VECTOR) && (r_src == SRC_B);
    assign w_soft_accept = w_code[c_BIT_SOFT] && (r_state == ST_IDLE) && !r_softreq;
    assign w_elig_a      = r_pend_a & r_en_a;
    assign w_elig_b      = r_pend_b & r_en_b;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_en_a  <= 1'b0;
            r_en_b  <= 1'b0;
            r_prio  <= 1'b0;
            r_vec_a <= INTA_DEFAULT;
            r_vec_b <= INTB_DEFAULT;
        end else begin
            if (w_code[c_BIT_SET_INFO]) begin
                r_en_a <= w_code[c_BIT_A_EN];
                r_en_b <= w_code[c_BIT_B_EN];
                r_prio <= w_code[c_BIT_PRIO];
            end
            if (w_addr_op == c_ADDR_SET_A) r_vec_a <= bus.i_data_bus;
            if (w_addr_op == c_ADDR_SET_B) r_vec_b <= bus.i_data_bus;
            if (w_addr_op == c_ADDR_DEFAULT) begin
                r_vec_a <= INTA_DEFAULT;
                r_vec_b <= INTB_DEFAULT;
            end
        end
    end

    // A fresh edge coinciding with the ack is kept as a new request.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_softreq  <= 1'b0;
            r_soft_num <= 5'd0;
        end else begin
            if (!r_en_a)       r_pend_a <= 1'b0;
            else if (w_rise_a) r_pend_a <= 1'b1;
            else if (w_ack_a)  r_pend_a <= 1'b0;
            if (!r_en_b)       r_pend_b <= 1'b0;
            else if (w_rise_b) r_pend_b <= 1'b1;
            else if (w_ack_b)  r_pend_b <= 1'b0;
            if (w_soft_accept) begin
                r_softreq  <= 1'b1;
                r_soft_num <= w_code[c_BIT_NUM_HI:c_BIT_NUM_LO];
            end else if ((r_state == ST_VECTOR) && (r_src == SRC_SOFT)) begin
                r_softreq  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_sel = SRC_NONE;
        if (r_softreq)                  w_sel = SRC_SOFT;
        else if (r_prio && w_elig_b)    w_sel = SRC_B;
        else if (w_elig_a)              w_sel = SRC_A;
        else if (w_elig_b)              w_sel = SRC_B;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_src   <= SRC_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        case (r_state)
            ST_IDLE: begin
                if (w_sel != SRC_NONE) begin
                    w_state_nxt = ST_SAVE;
                    w_src_nxt   = w_sel;
                end
            end
            ST_SAVE:    w_state_nxt = ST_VECTOR;
            ST_VECTOR:  w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (bus.i_iret) w_state_nxt = ST_RESTORE;
            ST_RESTORE: begin
                w_state_nxt = ST_IDLE;
                w_src_nxt   = SRC_NONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_src_nxt   = SRC_NONE;
            end
        endcase
    end

    always_comb begin
        w_vector = 16'h0000;
        if (r_state == ST_VECTOR) begin
            case (r_src)
                SRC_A:    w_vector = r_vec_a;
                SRC_B:    w_vector = r_vec_b;
                SRC_SOFT: w_vector = soft_vector(SOFT_VEC_BASE, r_soft_num);
                default:  w_vector = 16'h0000;
            endcase
        end
    end

    assign bus.o_interrupt  = (r_state == ST_SAVE);
    assign bus.o_pc_load    = (r_state == ST_VECTOR);
    assign bus.o_int_active = (r_state == ST_SERVICE);
    assign bus.o_restore    = (r_state == ST_RESTORE);
    assign bus.o_vector     = w_vector;
    assign bus.o_inta_ack   = w_ack_a;
    assign bus.o_intb_ack   = w_ack_b;
    assign bus.o_int_source = r_src;

`ifdef INT_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [8:0] w_drop_sum;
    logic       w_drop_a, w_drop_b;

    assign w_drop_a   = w_rise_a & r_pend_a & ~w_ack_a;
    assign w_drop_b   = w_rise_b & r_pend_b & ~w_ack_b;
    assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_drop_a} + {8'd0, w_drop_b};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                          r_drop_cnt <= 8'h00;
        else if (w_addr_op == c_ADDR_DEFAULT) r_drop_cnt <= 8'h00;
        else if (w_drop_sum[8])              r_drop_cnt <= 8'hFF;
        else                                 r_drop_cnt <= w_drop_sum[7:0];
    end

    assign bus.o_drop_cnt = r_drop_cnt;
`else
    assign bus.o_drop_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_int_controller
// Brief   : Directed self-checking bench for int_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_int_controller;

    localparam int c_S = 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int_controller_if bus();

    int_controller #(
        .SYNC_STAGES  (c_S),
        .INTA_DEFAULT (16'h0010),
        .INTB_DEFAULT (16'h0020),
        .SOFT_VEC_BASE(16'h0040)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Drive and sample 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_irq(input int bound, output int n);
        n = 0;
        while (bus.o_interrupt !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic write_code(input logic [11:0] code, input logic [15:0] data);
        bus.i_ct_control_code = code;
        bus.i_data_bus        = data;
        step();
        bus.i_ct_control_code = 12'h000;
        bus.i_data_bus        = 16'h0000;
    endtask

    function automatic logic [5:0] strobes();
        return {bus.o_interrupt, bus.o_restore, bus.o_pc_load,
                bus.o_inta_ack, bus.o_intb_ack, bus.o_int_active};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        steps(3);
        checks++;
        if (strobes() !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b, expected 000000", strobes());
        end
        checks++;
        if (bus.o_vector !== 16'h0000) begin
            errors++; $display("FAIL reset_vector: got %h, expected 0000", bus.o_vector);
        end
        checks++;
        if (bus.o_int_source !== 2'd0) begin
            errors++; $display("FAIL reset_source: got %0d, expected 0", bus.o_int_source);
        end
        checks++;
        if (bus.o_drop_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_drop: got %h, expected 00", bus.o_drop_cnt);
        end
        n_rst = 1'b1;
        steps(2);
    endtask

    task automatic test_hw_latency();
        int n;
        write_code(12'h00B, 16'h0000);
        step();
        bus.i_inta = 1'b1;
        wait_irq(20, n);
        checks++;
        if (n !== c_S + 2) begin
            errors++; $display("FAIL hw_latency: got %0d cycles, expected %0d", n, c_S + 2);
        end
        step();
        checks++;
        if ({bus.o_pc_load, bus.o_inta_ack, bus.o_intb_ack} !== 3'b110) begin
            errors++; $display("FAIL hw_vector_strobes: got %b, expected 110",
                               {bus.o_pc_load, bus.o_inta_ack, bus.o_intb_ack});
        end
        checks++;
        if (bus.o_vector !== 16'h0010) begin
            errors++; $display("FAIL hw_vector_a: got %h, expected 0010", bus.o_vector);
        end
        checks++;
        if (bus.o_int_source !== 2'd1) begin
            errors++; $display("FAIL hw_source_a: got %0d, expected 1", bus.o_int_source);
        end
        step();
        bus.i_iret = 1'b1;
        checks++;
        if (bus.o_int_active !== 1'b1) begin
            errors++; $display("FAIL hw_active: got %b, expected 1", bus.o_int_active);
        end
        step();
        bus.i_iret = 1'b0;
        bus.i_inta = 1'b0;
        checks++;
        if (bus.o_restore !== 1'b1) begin
            errors++; $display("FAIL hw_restore: got %b, expected 1", bus.o_restore);
        end
        step();
        checks++;
        if ({strobes(), bus.o_int_source} !== 8'h00) begin
            errors++; $display("FAIL hw_idle_after: got %b, expected 00000000",
                               {strobes(), bus.o_int_source});
        end
    endtask

    task automatic test_priority();
        int n;
        write_code(12'h02F, 16'h1234);
        step();
        bus.i_inta = 1'b1;
        bus.i_intb = 1'b1;
        wait_irq(20, n);
        checks++;
        if (n !== c_S + 2) begin
            errors++; $display("FAIL prio_latency: got %0d, expected %0d", n, c_S + 2);
        end
        step();
        checks++;
        if ({bus.o_vector, bus.o_int_source, bus.o_intb_ack, bus.o_inta_ack} !==
            {16'h1234, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL prio_b_first: got vec=%h src=%0d ackb=%b acka=%b, expected vec=1234 src=2 ackb=1 acka=0",
                               bus.o_vector, bus.o_int_source, bus.o_intb_ack, bus.o_inta_ack);
        end
        step();
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        bus.i_inta = 1'b0;
        bus.i_intb = 1'b0;
        step();
        checks++;
        if (bus.o_interrupt !== 1'b0) begin
            errors++; $display("FAIL prio_idle_gap: got %b, expected 0", bus.o_interrupt);
        end
        step();
        checks++;
        if (bus.o_interrupt !== 1'b1) begin
            errors++; $display("FAIL prio_a_second: got %b, expected 1", bus.o_interrupt);
        end
        step();
        checks++;
        if ({bus.o_vector, bus.o_inta_ack} !== {16'h0010, 1'b1}) begin
            errors++; $display("FAIL prio_a_vector: got vec=%h acka=%b, expected vec=0010 acka=1",
                               bus.o_vector, bus.o_inta_ack);
        end
        step();
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        step();
    endtask

    task automatic test_soft();
        step();
        bus.i_inta = 1'b1;
        steps(2);
        bus.i_ct_control_code = 12'h2C0;
        step();
        bus.i_ct_control_code = 12'h000;
        checks++;
        if (bus.o_interrupt !== 1'b0) begin
            errors++; $display("FAIL soft_early: got %b, expected 0", bus.o_interrupt);
        end
        step();
        checks++;
        if ({bus.o_interrupt, bus.o_int_source} !== 3'b1_11) begin
            errors++; $display("FAIL soft_latency_src: got irq=%b src=%0d, expected irq=1 src=3",
                               bus.o_interrupt, bus.o_int_source);
        end
        step();
        checks++;
        if ({bus.o_vector, bus.o_inta_ack, bus.o_pc_load} !== {16'h004A, 1'b0, 1'b1}) begin
            errors++; $display("FAIL soft_vector: got vec=%h acka=%b load=%b, expected vec=004a acka=0 load=1",
                               bus.o_vector, bus.o_inta_ack, bus.o_pc_load);
        end
        step();
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        bus.i_inta = 1'b0;
        steps(3);
        checks++;
        if ({bus.o_vector, bus.o_inta_ack, bus.o_int_source} !== {16'h0010, 1'b1, 2'd1}) begin
            errors++; $display("FAIL soft_then_a: got vec=%h acka=%b src=%0d, expected vec=0010 acka=1 src=1",
                               bus.o_vector, bus.o_inta_ack, bus.o_int_source);
        end
        step();
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        step();
    endtask

    task automatic test_masked();
        int seen;
        write_code(12'h00A, 16'h0000);
        bus.i_inta = 1'b1;
        steps(2);
        bus.i_inta = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.o_interrupt === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL masked_no_irq: got %0d irq cycles, expected 0", seen);
        end
        write_code(12'h00B, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.o_interrupt === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL masked_discarded: got %0d irq cycles, expected 0", seen);
        end
    endtask

    task automatic pulse_a(input int count);
        for (int i = 0; i < count; i++) begin
            bus.i_inta = 1'b1;
            steps(2);
            bus.i_inta = 1'b0;
            steps(2);
        end
        steps(c_S + 1);
    endtask

    task automatic test_drop();
        int n;
        step();
        bus.i_intb = 1'b1;
        wait_irq(20, n);
        bus.i_intb = 1'b0;
        steps(2);
        pulse_a(3);
        checks++;
        if (bus.o_int_active !== 1'b1) begin
            errors++; $display("FAIL drop_still_service: got %b, expected 1", bus.o_int_active);
        end
`ifdef INT_DROP_CNT_EN
        checks++;
        if (bus.o_drop_cnt !== 8'd2) begin
            errors++; $display("FAIL drop_cnt_2: got %0d, expected 2", bus.o_drop_cnt);
        end
`endif
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        wait_irq(20, n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL drop_a_served: got %0d cycles, expected 2", n);
        end
        step();
        checks++;
        if (bus.o_inta_ack !== 1'b1) begin
            errors++; $display("FAIL drop_a_ack: got %b, expected 1", bus.o_inta_ack);
        end
        step();
        pulse_a(301);
`ifdef INT_DROP_CNT_EN
        checks++;
        if (bus.o_drop_cnt !== 8'hFF) begin
            errors++; $display("FAIL drop_cnt_sat: got %h, expected ff", bus.o_drop_cnt);
        end
`else
        checks++;
        if (bus.o_drop_cnt !== 8'h00) begin
            errors++; $display("FAIL drop_cnt_tied: got %h, expected 00", bus.o_drop_cnt);
        end
`endif
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        wait_irq(20, n);
        steps(2);
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        step();
        checks++;
        if (strobes() !== 6'b0) begin
            errors++; $display("FAIL drop_single_service: got %b, expected 000000", strobes());
        end
        write_code(12'h030, 16'h0000);
        checks++;
        if (bus.o_drop_cnt !== 8'h00) begin
            errors++; $display("FAIL drop_cnt_clear: got %h, expected 00", bus.o_drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int seen;
        write_code(12'h020, 16'h1234);
        step();
        bus.i_intb = 1'b1;
        wait_irq(20, n);
        step();
        checks++;
        if (bus.o_vector !== 16'h1234) begin
            errors++; $display("FAIL rst_pre_vector: got %h, expected 1234", bus.o_vector);
        end
        step();
        bus.i_intb = 1'b0;
        pulse_a(1);
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({strobes(), bus.o_int_source, bus.o_vector, bus.o_drop_cnt} !== 32'h0) begin
            errors++; $display("FAIL rst_async_outputs: got strobes=%b src=%0d vec=%h drop=%h, expected all zero",
                               strobes(), bus.o_int_source, bus.o_vector, bus.o_drop_cnt);
        end
        steps(2);
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.o_interrupt === 1'b1) seen++;
        end
        write_code(12'h00B, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.o_interrupt === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_no_residual: got %0d irq cycles, expected 0", seen);
        end
        bus.i_intb = 1'b1;
        wait_irq(20, n);
        step();
        checks++;
        if ({bus.o_vector, bus.o_intb_ack} !== {16'h0020, 1'b1}) begin
            errors++; $display("FAIL rst_default_vec_b: got vec=%h ackb=%b, expected vec=0020 ackb=1",
                               bus.o_vector, bus.o_intb_ack);
        end
        bus.i_intb = 1'b0;
        step();
        bus.i_iret = 1'b1;
        step();
        bus.i_iret = 1'b0;
        step();
    endtask

    initial begin
        bus.i_ct_control_code = 12'h000;
        bus.i_data_bus        = 16'h0000;
        bus.i_inta            = 1'b0;
        bus.i_intb            = 1'b0;
        bus.i_iret            = 1'b0;
        test_reset();
        test_hw_latency();
        test_priority();
        test_soft();
        test_masked();
        test_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
